// File: rtl/line_buffer_3row.sv
// Three-row line buffer: turns a raster pixel stream into vertically aligned row taps for a 3x3 window.
// Optional LINE_BUFFER_BORDER_REPLICATE_EN emits rows 0/1 with top-edge replication instead of priming.
module line_buffer_3row #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned PIC_WIDTH  = 480,
  parameter int unsigned PIC_HEIGHT = 272
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             valid_out,
  output logic             line_last,
  output logic             frame_last
);

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned ADDR_W = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [WIDTH-1:0] dout1_q, dout1_d;
  logic [WIDTH-1:0] dout2_q, dout2_d;
  logic [WIDTH-1:0] dout3_q, dout3_d;
  logic             valid_out_q, valid_out_d;
  logic             line_last_q, line_last_d;
  logic             frame_last_q, frame_last_d;

  // Line memories: line1 holds row r-1, line2 holds row r-2; contents are never reset.
  logic [WIDTH-1:0] line1_mem [PIC_WIDTH];
  logic [WIDTH-1:0] line2_mem [PIC_WIDTH];

  logic [ADDR_W-1:0] addr_c;
  logic [WIDTH-1:0]  rd_a_c;
  logic [WIDTH-1:0]  rd_b_c;
  logic              col_last_c;
  logic              row_last_c;
  logic              emit_c;

  assign addr_c     = ADDR_W'(col_q);
  assign rd_a_c     = line1_mem[addr_c];
  assign rd_b_c     = line2_mem[addr_c];
  assign col_last_c = (col_q == CNT_W'(PIC_WIDTH - 1));
  assign row_last_c = (row_q == CNT_W'(PIC_HEIGHT - 1));

`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
  assign emit_c = 1'b1;
`else
  assign emit_c = (row_q >= CNT_W'(2));
`endif

  // Next-state: raster counters and output register, all frozen when valid_in is low.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    dout1_d      = dout1_q;
    dout2_d      = dout2_q;
    dout3_d      = dout3_q;
    valid_out_d  = valid_in && emit_c;
    line_last_d  = valid_in && emit_c && col_last_c;
    frame_last_d = valid_in && emit_c && col_last_c && row_last_c;

    if (valid_in) begin
      col_d = col_last_c ? '0 : col_q + CNT_W'(1);
      if (col_last_c) begin
        row_d = row_last_c ? '0 : row_q + CNT_W'(1);
      end
      dout3_d = din;
      dout2_d = rd_a_c;
      dout1_d = rd_b_c;
`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
      // Replicate the top edge: row 0 mirrors itself, row 1 borrows row 0 for the top tap.
      if (row_q == CNT_W'(0)) begin
        dout2_d = din;
        dout1_d = din;
      end else if (row_q == CNT_W'(1)) begin
        dout1_d = rd_a_c;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      dout1_q      <= '0;
      dout2_q      <= '0;
      dout3_q      <= '0;
      valid_out_q  <= 1'b0;
      line_last_q  <= 1'b0;
      frame_last_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      dout1_q      <= dout1_d;
      dout2_q      <= dout2_d;
      dout3_q      <= dout3_d;
      valid_out_q  <= valid_out_d;
      line_last_q  <= line_last_d;
      frame_last_q <= frame_last_d;
    end
  end

  // Read-before-write: the taps above sample old contents in the same cycle as this shift.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      line1_mem[addr_c] <= din;
      line2_mem[addr_c] <= rd_a_c;
    end
  end

  assign dout1      = dout1_q;
  assign dout2      = dout2_q;
  assign dout3      = dout3_q;
  assign valid_out  = valid_out_q;
  assign line_last  = line_last_q;
  assign frame_last = frame_last_q;

endmodule
